// File: rtl/ctrl_bus_pkg.sv
// Shared types, register map and request legality rules for the control-bus sequencer.
package ctrl_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    LOAD   = 2'd2,
    HOLD   = 2'd3
  } state_e;

  localparam int MAX_REGS = 64;
  localparam int CNT_W    = 8;

  localparam int REG_A    = 0;
  localparam int REG_B    = 1;
  localparam int REG_C    = 2;
  localparam int REG_D    = 3;
  localparam int REG_M1   = 4;
  localparam int REG_M2   = 5;
  localparam int REG_X    = 6;
  localparam int REG_Y    = 7;
  localparam int REG_J1   = 8;
  localparam int REG_J2   = 9;
  localparam int REG_PC   = 10;
  localparam int REG_INC  = 11;
  localparam int REG_INST = 12;
  localparam int REG_CCR  = 13;

  // Relay machine: 14 registers; J1, J2 and CCR are load-only.
  localparam logic [15:0] RELAY_SEL_MASK = 16'h1CFF;
  localparam logic [15:0] RELAY_LD_MASK  = 16'h3FFF;

  function automatic logic req_legal(input int unsigned num_regs,
                                     input logic [31:0] src,
                                     input logic [MAX_REGS-1:0] dst,
                                     input logic [MAX_REGS-1:0] sel_mask,
                                     input logic [MAX_REGS-1:0] ld_mask,
                                     input logic clr);
    logic ok;
    ok = 1'b1;
    if (dst == '0) ok = 1'b0;
    if ((dst & ~ld_mask) != '0) ok = 1'b0;
    if (!clr) begin
      if (src >= num_regs) ok = 1'b0;
      else if (!sel_mask[src[5:0]] || dst[src[5:0]]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/ctrl_bus_timer.sv
// Loadable down-counter with a zero flag; reloaded on every sequencer state entry.
module ctrl_bus_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) count_d = load_val_i;
    else if (count_q != '0) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/ctrl_bus_sequencer.sv
// Break-before-make select/load sequencer for a shared register bus.
// Optional CTRL_BUS_CLR_EN adds req_clr: load zeros into destinations with no source selected.
module ctrl_bus_sequencer
  import ctrl_bus_pkg::*;
#(
  parameter int                  NUM_REGS   = 16,
  parameter int                  IDX_W      = $clog2(NUM_REGS),
  parameter logic [NUM_REGS-1:0] SEL_MASK   = {NUM_REGS{1'b1}},
  parameter logic [NUM_REGS-1:0] LD_MASK    = {NUM_REGS{1'b1}},
  parameter int                  SETTLE_CYC = 2,
  parameter int                  LOAD_CYC   = 1,
  parameter int                  HOLD_CYC   = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [IDX_W-1:0]    req_src,
  input  logic [NUM_REGS-1:0] req_dst,
`ifdef CTRL_BUS_CLR_EN
  input  logic                req_clr,
`endif
  output logic [NUM_REGS-1:0] sel,
  output logic [NUM_REGS-1:0] ld,
  output logic                busy,
  output logic                done,
  output logic                err
);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    src_q, src_d;
  logic [NUM_REGS-1:0] dst_q, dst_d;
  logic                clr_q, clr_d;
  logic [NUM_REGS-1:0] sel_q, sel_d, ld_q, ld_d;
  logic                busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic                tmr_load, tmr_zero;
  logic [CNT_W-1:0]    tmr_val;
  logic                req_clr_w, accept, legal;

`ifdef CTRL_BUS_CLR_EN
  assign req_clr_w = req_clr;
`else
  assign req_clr_w = 1'b0;
`endif

  assign req_ready = (state_q == IDLE) && !reset;
  assign accept    = req_valid && req_ready;
  assign legal     = req_legal(NUM_REGS, 32'(req_src), MAX_REGS'(req_dst),
                               MAX_REGS'(SEL_MASK), MAX_REGS'(LD_MASK), req_clr_w);

  ctrl_bus_timer #(.W(CNT_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    clr_d    = clr_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (legal) begin
            state_d  = SETTLE;
            src_d    = req_src;
            dst_d    = req_dst;
            clr_d    = req_clr_w;
            tmr_load = 1'b1;
            tmr_val  = CNT_W'(SETTLE_CYC - 1);
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SETTLE: begin
        if (tmr_zero) begin
          state_d  = LOAD;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(LOAD_CYC - 1);
        end
      end
      LOAD: begin
        if (tmr_zero) begin
          if (HOLD_CYC > 0) begin
            state_d  = HOLD;
            tmr_load = 1'b1;
            tmr_val  = CNT_W'(HOLD_CYC - 1);
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      HOLD: begin
        if (tmr_zero) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Outputs are decoded from the next state so they line up with it once registered.
    busy_d = (state_d != IDLE);
    sel_d  = (busy_d && !clr_d) ? (NUM_REGS'(1) << src_d) : '0;
    ld_d   = (state_d == LOAD) ? dst_d : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      clr_q   <= 1'b0;
      sel_q   <= '0;
      ld_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      clr_q   <= clr_d;
      sel_q   <= sel_d;
      ld_q    <= ld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign sel  = sel_q;
  assign ld   = ld_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_ctrl_bus_sequencer.sv
// Self-checking bench: directed and random transfers against a timeline model of the sequencer.
module tb_ctrl_bus_sequencer;
  import ctrl_bus_pkg::*;

  localparam logic [15:0] M_SEL1 = 16'h1CFF;  // J1, J2, CCR have no select; 14/15 absent
  localparam logic [15:0] M_LD1  = 16'h3FFF;
  localparam logic [15:0] M_ALL  = 16'hFFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [3:0]  req_src = '0;
  logic [15:0] req_dst = '0;
  logic        req_clr = 1'b0;
  bit          use2 = 1'b0;

  logic        rdy1, rdy2, busy1, busy2, done1, done2, err1, err2;
  logic [15:0] sel1, sel2, ld1, ld2;
  logic        v1, v2;

  int n_tests = 0;
  int n_fail  = 0;

  assign v1 = req_valid && !use2;
  assign v2 = req_valid && use2;

  always #5 clk = ~clk;

  ctrl_bus_sequencer #(
    .NUM_REGS(16), .SEL_MASK(RELAY_SEL_MASK), .LD_MASK(RELAY_LD_MASK)
  ) dut1 (
    .clk(clk), .reset(rst), .req_valid(v1), .req_ready(rdy1),
    .req_src(req_src), .req_dst(req_dst),
`ifdef CTRL_BUS_CLR_EN
    .req_clr(req_clr),
`endif
    .sel(sel1), .ld(ld1), .busy(busy1), .done(done1), .err(err1)
  );

  ctrl_bus_sequencer #(
    .NUM_REGS(16), .SETTLE_CYC(1), .LOAD_CYC(2), .HOLD_CYC(0)
  ) dut2 (
    .clk(clk), .reset(rst), .req_valid(v2), .req_ready(rdy2),
    .req_src(req_src), .req_dst(req_dst),
`ifdef CTRL_BUS_CLR_EN
    .req_clr(req_clr),
`endif
    .sel(sel2), .ld(ld2), .busy(busy2), .done(done2), .err(err2)
  );

  logic        o_ready, o_busy, o_done, o_err;
  logic [15:0] o_sel, o_ld;
  logic [63:0] obs;
  assign o_ready = use2 ? rdy2  : rdy1;
  assign o_busy  = use2 ? busy2 : busy1;
  assign o_done  = use2 ? done2 : done1;
  assign o_err   = use2 ? err2  : err1;
  assign o_sel   = use2 ? sel2  : sel1;
  assign o_ld    = use2 ? ld2   : ld1;
  assign obs     = {28'b0, o_ready, o_busy, o_done, o_err, o_ld, o_sel};

  function automatic logic [63:0] pk(input bit rdy, input bit b, input bit d, input bit e,
                                     input logic [15:0] l, input logic [15:0] s);
    return {28'b0, rdy, b, d, e, l, s};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit exp_legal(input int src, input logic [15:0] dst, input bit clr,
                                   input logic [15:0] selm, input logic [15:0] ldm);
    if (dst == 16'h0) return 1'b0;
    if ((dst & ~ldm) != 16'h0) return 1'b0;
    if (clr) return 1'b1;
    return selm[src] && !dst[src];
  endfunction

  // Issue one request and check every cycle until done (or the err pulse).
  // With keep set, the follow-up request is held valid during the transfer.
  task automatic run_req(input int src_v, input logic [15:0] dst_v, input bit clr_v,
                         input bit keep, input int src_n, input logic [15:0] dst_n,
                         input bit clr_n);
    int s, l, h, n, wc;
    bit lg;
    logic [15:0] sel_e, ld_e;
    s = use2 ? 1 : 2;
    l = use2 ? 2 : 1;
    h = use2 ? 0 : 1;
    n = s + l + h;
    wc = 0;
    while (!o_ready && wc < 30) begin
      @(posedge clk); #1;
      wc++;
    end
    if (!o_ready) begin
      check("rdy_wait", {63'b0, o_ready}, 64'd1);
      return;
    end
    req_valid = 1'b1;
    req_src   = 4'(src_v);
    req_dst   = dst_v;
    req_clr   = clr_v;
    lg = exp_legal(src_v, dst_v, clr_v, use2 ? M_ALL : M_SEL1, use2 ? M_ALL : M_LD1);
    @(posedge clk); #1;
    if (keep) begin
      req_src = 4'(src_n);
      req_dst = dst_n;
      req_clr = clr_n;
    end else begin
      req_valid = 1'b0;
      req_src   = 4'($urandom);
      req_dst   = 16'($urandom);
      req_clr   = 1'($urandom);
    end
    if (!lg) begin
      check($sformatf("illegal src%0d dst%0h", src_v, dst_v), obs, pk(1, 0, 0, 1, 16'h0, 16'h0));
      if (!keep) begin
        @(posedge clk); #1;
        check("err_drop", obs, pk(1, 0, 0, 0, 16'h0, 16'h0));
      end
      return;
    end
    for (int k = 1; k <= n + 1; k++) begin
      sel_e = (k <= n && !clr_v) ? (16'h1 << src_v) : 16'h0;
      ld_e  = (k > s && k <= s + l) ? dst_v : 16'h0;
      check($sformatf("xfer d%0d src%0d dst%0h k%0d", use2 ? 2 : 1, src_v, dst_v, k), obs,
            pk(k == n + 1, k <= n, k == n + 1, 0, ld_e, sel_e));
      if (k <= n) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic gen(output int src, output logic [15:0] dst, output bit clr);
    int r;
    src = $urandom_range(0, 15);
    r   = $urandom_range(0, 9);
    if (r == 0) dst = 16'h0;
    else if (r == 1) dst = 16'($urandom) | (16'h1 << src);
    else if (r < 5) dst = 16'($urandom);
    else dst = 16'($urandom) & 16'h3FFF & ~(16'h1 << src);
`ifdef CTRL_BUS_CLR_EN
    clr = ($urandom_range(0, 3) == 0);
`else
    clr = 1'b0;
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cs, ns;
    logic [15:0] cd, nd;
    bit cc, nc, kp, kp_prev;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_d1", obs, pk(0, 0, 0, 0, 16'h0, 16'h0));
    use2 = 1'b1; #1;
    check("reset_d2", obs, pk(0, 0, 0, 0, 16'h0, 16'h0));
    use2 = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_reset", obs, pk(1, 0, 0, 0, 16'h0, 16'h0));

    // Directed: default timing
    run_req(REG_A, 16'h0002, 0, 0, 0, 16'h0, 0);
    run_req(REG_INC, 16'h0440, 0, 0, 0, 16'h0, 0);
    run_req(0, 16'h0001, 0, 0, 0, 16'h0, 0);
    run_req(3, 16'h0000, 0, 0, 0, 16'h0, 0);
    run_req(REG_J1, 16'h0001, 0, 0, 0, 16'h0, 0);
    run_req(REG_A, 16'h0002, 0, 1, REG_C, 16'h0008, 0);
    run_req(REG_C, 16'h0008, 0, 0, 0, 16'h0, 0);
`ifdef CTRL_BUS_CLR_EN
    run_req(5, 16'h0001, 1, 0, 0, 16'h0, 0);
`endif

    // Reset during LOAD
    run_req_reset();

    // Directed: short timing instance
    use2 = 1'b1; #1;
    run_req(1, 16'h0010, 0, 0, 0, 16'h0, 0);
    run_req(REG_J1, 16'h0001, 0, 0, 0, 16'h0, 0);

    // Random, both instances
    for (int pass = 0; pass < 2; pass++) begin
      use2 = (pass == 1); #1;
      kp_prev = 1'b0;
      gen(ns, nd, nc);
      for (int i = 0; i < 40; i++) begin
        cs = ns; cd = nd; cc = nc;
        gen(ns, nd, nc);
        kp = ($urandom_range(0, 2) == 0) && (i < 39);
        run_req(cs, cd, cc, kp, ns, nd, nc);
        if (!kp) gen(ns, nd, nc);
        kp_prev = kp;
      end
      req_valid = 1'b0;
      repeat (8) @(posedge clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  task automatic run_req_reset();
    int wc;
    wc = 0;
    while (!o_ready && wc < 30) begin
      @(posedge clk); #1;
      wc++;
    end
    req_valid = 1'b1;
    req_src   = 4'(REG_B);
    req_dst   = 16'h0001;
    req_clr   = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pre_load", obs, pk(0, 1, 0, 0, 16'h0001, 16'h0002));
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid", obs, pk(0, 0, 0, 0, 16'h0, 16'h0));
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_after", obs, pk(1, 0, 0, 0, 16'h0, 16'h0));
    @(posedge clk); #1;
    check("rst_no_done", obs, pk(1, 0, 0, 0, 16'h0, 16'h0));
  endtask

endmodule
